// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Registers the EX-stage operand selects and inserts load-use bubbles.
module fwd_hazard_unit #(
  parameter int REG_AW    = 5,
  parameter int NUM_SRC   = 2,
  parameter int STALL_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic [REG_AW-1:0]         mem_rd,
  input  logic                      mem_reg_write,
  input  logic                      stall_ext,
  input  logic                      flush,
  output logic [2*NUM_SRC-1:0]      fw_sel,
  output logic                      stall_id,
  output logic                      bubble_ex,
  output logic [CNT_W-1:0]          stall_count
);

  typedef enum logic {ST_RUN, ST_LU_WAIT} state_t;

  localparam logic [3:0]        LP_CNT_INIT = 4'(STALL_CYC - 1);
  localparam logic [REG_AW-1:0] LP_X0       = '0;
  localparam bit                LP_MULTI    = (STALL_CYC > 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_cnt;
  logic [3:0]           w_cnt_nxt;
  logic [NUM_SRC-1:0]   w_match_ex;
  logic [NUM_SRC-1:0]   w_match_mem;
  logic [2*NUM_SRC-1:0] w_sel_nxt;
  logic                 w_hazard;
  logic                 w_stall;
  logic [2*NUM_SRC-1:0] r_fw_sel;
  logic [CNT_W-1:0]     r_stall_count;

  // EX is the newer producer, so its match wins over MEM.
  always_comb begin
    w_match_ex  = '0;
    w_match_mem = '0;
    w_sel_nxt   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_match_ex[i]  = id_rs_used[i] & ex_reg_write & (ex_rd != LP_X0) &
                       (ex_rd == id_rs[i*REG_AW +: REG_AW]);
      w_match_mem[i] = id_rs_used[i] & mem_reg_write & (mem_rd != LP_X0) &
                       (mem_rd == id_rs[i*REG_AW +: REG_AW]);
      if (w_match_ex[i]) begin
        w_sel_nxt[2*i +: 2] = 2'b10;
      end else if (w_match_mem[i]) begin
        w_sel_nxt[2*i +: 2] = 2'b01;
      end
    end
  end

  assign w_hazard = id_valid & ex_mem_read & (|w_match_ex);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (flush) begin
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = '0;
    end else if (!stall_ext) begin
      case (r_state)
        ST_RUN: begin
          if (w_hazard && LP_MULTI) begin
            w_state_nxt = ST_LU_WAIT;
            w_cnt_nxt   = LP_CNT_INIT;
          end
        end
        ST_LU_WAIT: begin
          w_cnt_nxt = r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // A frozen or redirected pipeline never takes a bubble.
  always_comb begin
    w_stall = 1'b0;
    if (!arst && !flush && !stall_ext) begin
      case (r_state)
        ST_RUN:     w_stall = w_hazard;
        ST_LU_WAIT: w_stall = 1'b1;
        default:    w_stall = 1'b0;
      endcase
    end
  end

  assign stall_id  = w_stall;
  assign bubble_ex = w_stall;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_fw_sel <= '0;
    end else if (flush) begin
      r_fw_sel <= '0;
    end else if (stall_ext) begin
      r_fw_sel <= r_fw_sel;
    end else if (w_stall) begin
      r_fw_sel <= '0;
    end else begin
      r_fw_sel <= w_sel_nxt;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign fw_sel      = r_fw_sel;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench: three fwd_hazard_unit instances (1, 3 and 4 bubbles)
// driven in parallel and checked every cycle against a bubble-budget model.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       arst;
  logic       idValid;
  logic [9:0] idRs;
  logic [1:0] idRsUsed;
  logic [4:0] exRd;
  logic       exRegWrite;
  logic       exMemRead;
  logic [4:0] memRd;
  logic       memRegWrite;
  logic       stallExt;
  logic       flush;

  logic [3:0]  fwSel1, fwSel3, fwSel4;
  logic        stall1, stall3, stall4;
  logic        bubble1, bubble3, bubble4;
  logic [15:0] count1, count4;
  logic [3:0]  count3;

  int nCompared   = 0;
  int nMismatched = 0;

  int          stallCyc [3] = '{1, 3, 4};
  int          cntMax   [3] = '{65535, 15, 65535};
  int          mRem     [3];
  logic [3:0]  mFw      [3];
  int          mCnt     [3];

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .STALL_CYC(1), .CNT_W(16)) dut1 (
    .clk(clk), .arst(arst), .id_valid(idValid), .id_rs(idRs), .id_rs_used(idRsUsed),
    .ex_rd(exRd), .ex_reg_write(exRegWrite), .ex_mem_read(exMemRead),
    .mem_rd(memRd), .mem_reg_write(memRegWrite), .stall_ext(stallExt), .flush(flush),
    .fw_sel(fwSel1), .stall_id(stall1), .bubble_ex(bubble1), .stall_count(count1));

  fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .STALL_CYC(3), .CNT_W(4)) dut3 (
    .clk(clk), .arst(arst), .id_valid(idValid), .id_rs(idRs), .id_rs_used(idRsUsed),
    .ex_rd(exRd), .ex_reg_write(exRegWrite), .ex_mem_read(exMemRead),
    .mem_rd(memRd), .mem_reg_write(memRegWrite), .stall_ext(stallExt), .flush(flush),
    .fw_sel(fwSel3), .stall_id(stall3), .bubble_ex(bubble3), .stall_count(count3));

  fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .STALL_CYC(4), .CNT_W(16)) dut4 (
    .clk(clk), .arst(arst), .id_valid(idValid), .id_rs(idRs), .id_rs_used(idRsUsed),
    .ex_rd(exRd), .ex_reg_write(exRegWrite), .ex_mem_read(exMemRead),
    .mem_rd(memRd), .mem_reg_write(memRegWrite), .stall_ext(stallExt), .flush(flush),
    .fw_sel(fwSel4), .stall_id(stall4), .bubble_ex(bubble4), .stall_count(count4));

  // Operand selects straight from the match rules: EX beats MEM, x0 never matches.
  function automatic logic [3:0] modelSel();
    logic [3:0] s;
    logic [4:0] rs;
    s = '0;
    for (int i = 0; i < 2; i++) begin
      rs = idRs[i*5 +: 5];
      if (idRsUsed[i] && exRegWrite && exRd != 5'd0 && exRd == rs)
        s[2*i +: 2] = 2'b10;
      else if (idRsUsed[i] && memRegWrite && memRd != 5'd0 && memRd == rs)
        s[2*i +: 2] = 2'b01;
    end
    return s;
  endfunction

  function automatic bit modelHazard();
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 2; i++)
      if (idRsUsed[i] && exRegWrite && exRd != 5'd0 && exRd == idRs[i*5 +: 5]) hit = 1'b1;
    return idValid && exMemRead && hit;
  endfunction

  function automatic void resetModel();
    for (int k = 0; k < 3; k++) begin
      mRem[k] = 0;
      mFw[k]  = '0;
      mCnt[k] = 0;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The model tracks how many bubbles each instance still owes.
  always @(posedge clk) begin
    bit hz;
    bit st;
    logic [3:0] sel;
    if (arst) begin
      resetModel();
    end else if (flush) begin
      for (int k = 0; k < 3; k++) begin
        mRem[k] = 0;
        mFw[k]  = '0;
      end
    end else if (!stallExt) begin
      hz  = modelHazard();
      sel = modelSel();
      for (int k = 0; k < 3; k++) begin
        st = (mRem[k] > 0) || hz;
        if (st) begin
          if (mCnt[k] < cntMax[k]) mCnt[k]++;
          if (mRem[k] > 0) mRem[k]--;
          else mRem[k] = stallCyc[k] - 1;
          mFw[k] = '0;
        end else begin
          mFw[k] = sel;
        end
      end
    end
  end

  initial begin
    logic [3:0]  actFw     [3];
    logic        actStall  [3];
    logic        actBubble [3];
    logic [15:0] actCnt    [3];
    bit          expStall;
    forever begin
      @(negedge clk);
      if (arst) resetModel();
      actFw     = '{fwSel1, fwSel3, fwSel4};
      actStall  = '{stall1, stall3, stall4};
      actBubble = '{bubble1, bubble3, bubble4};
      actCnt    = '{count1, {12'd0, count3}, count4};
      for (int k = 0; k < 3; k++) begin
        expStall = !arst && !flush && !stallExt && ((mRem[k] > 0) || modelHazard());
        checkOutput($sformatf("model stall_id S=%0d", stallCyc[k]), 32'(actStall[k]), 32'(expStall));
        checkOutput($sformatf("model bubble_ex S=%0d", stallCyc[k]), 32'(actBubble[k]), 32'(expStall));
        checkOutput($sformatf("model fw_sel S=%0d", stallCyc[k]), 32'(actFw[k]), 32'(mFw[k]));
        checkOutput($sformatf("model stall_count S=%0d", stallCyc[k]), 32'(actCnt[k]), 32'(mCnt[k]));
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                               input logic [1:0] used, input logic [4:0] eRd, input logic eWe,
                               input logic eMr, input logic [4:0] mRd, input logic mWe,
                               input logic sExt, input logic fl);
    idValid     = v;
    idRs        = {rs1, rs0};
    idRsUsed    = used;
    exRd        = eRd;
    exRegWrite  = eWe;
    exMemRead   = eMr;
    memRd       = mRd;
    memRegWrite = mWe;
    stallExt    = sExt;
    flush       = fl;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    arst = 1'b1;
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    stepCycle();
    #3 arst = 1'b0;
  endtask

  initial begin
    arst = 1'b1;
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("reset fw_sel", 32'(fwSel1), 32'd0);
    checkOutput("reset stall_count", 32'(count1), 32'd0);
    checkOutput("reset stall_id", 32'(stall4), 32'd0);
    stepCycle();
    stepCycle();
    #3 arst = 1'b0;

    // Back-to-back ALU dependency on source 0.
    applyStimulus(1, 5, 0, 2'b01, 5, 1, 0, 0, 0, 0, 0);
    #2 checkOutput("alu dep stall_id", 32'(stall1), 32'd0);
    stepCycle();
    checkOutput("alu dep fw_sel[1:0]", 32'(fwSel1[1:0]), 32'h2);

    // Both EX and MEM produce x5; EX wins. Then x0 never forwards.
    applyStimulus(1, 0, 5, 2'b10, 5, 1, 0, 5, 1, 0, 0);
    stepCycle();
    checkOutput("double hazard fw_sel[3:2]", 32'(fwSel1[3:2]), 32'h2);
    applyStimulus(1, 0, 0, 2'b11, 0, 1, 0, 0, 1, 0, 0);
    stepCycle();
    checkOutput("x0 fw_sel", 32'(fwSel1), 32'h0);

    // Load-use with a single bubble.
    doReset();
    applyStimulus(1, 7, 0, 2'b01, 7, 1, 1, 0, 0, 0, 0);
    #2;
    checkOutput("lu1 stall_id", 32'(stall1), 32'd1);
    checkOutput("lu1 bubble_ex", 32'(bubble1), 32'd1);
    stepCycle();
    applyStimulus(1, 7, 0, 2'b01, 0, 0, 0, 7, 1, 0, 0);
    #2;
    checkOutput("lu1 stall released", 32'(stall1), 32'd0);
    checkOutput("lu1 bubble fw_sel", 32'(fwSel1), 32'h0);
    stepCycle();
    checkOutput("lu1 consumer fw_sel[1:0]", 32'(fwSel1[1:0]), 32'h1);
    checkOutput("lu1 stall_count", 32'(count1), 32'd1);

    // Three bubbles with a two-cycle freeze in the middle.
    doReset();
    applyStimulus(1, 7, 0, 2'b01, 7, 1, 1, 0, 0, 0, 0);
    #2 checkOutput("lu3 first stall", 32'(stall3), 32'd1);
    stepCycle();
    applyStimulus(1, 7, 0, 2'b01, 0, 0, 0, 7, 1, 1, 0);
    #2 checkOutput("lu3 frozen stall_id", 32'(stall3), 32'd0);
    stepCycle();
    checkOutput("lu3 frozen count", 32'(count3), 32'd1);
    stepCycle();
    checkOutput("lu3 frozen fw_sel", 32'(fwSel3), 32'h0);
    stallExt = 1'b0;
    #2 checkOutput("lu3 resumed stall", 32'(stall3), 32'd1);
    stepCycle();
    #2 checkOutput("lu3 last stall", 32'(stall3), 32'd1);
    stepCycle();
    #2;
    checkOutput("lu3 released", 32'(stall3), 32'd0);
    checkOutput("lu3 stall_count", 32'(count3), 32'd3);

    // Flush on the second stall cycle of a four-bubble hazard.
    doReset();
    applyStimulus(1, 7, 0, 2'b01, 7, 1, 1, 0, 0, 0, 0);
    #2 checkOutput("lu4 first stall", 32'(stall4), 32'd1);
    stepCycle();
    applyStimulus(1, 5, 0, 2'b01, 5, 1, 0, 0, 0, 0, 1);
    #2 checkOutput("lu4 flush stall_id", 32'(stall4), 32'd0);
    stepCycle();
    checkOutput("lu4 flush fw_sel", 32'(fwSel4), 32'h0);
    flush = 1'b0;
    #2 checkOutput("lu4 after flush runs", 32'(stall4), 32'd0);
    stepCycle();
    checkOutput("lu4 after flush fw_sel", 32'(fwSel4), 32'h2);

    // Asynchronous reset in the middle of the wait state.
    doReset();
    applyStimulus(1, 7, 0, 2'b01, 7, 1, 1, 0, 0, 0, 0);
    stepCycle();
    applyStimulus(1, 7, 0, 2'b01, 0, 0, 0, 7, 1, 0, 0);
    #1 checkOutput("arst pre stall", 32'(stall4), 32'd1);
    #1 arst = 1'b1;
    #1;
    checkOutput("arst async count", 32'(count4), 32'd0);
    checkOutput("arst async stall", 32'(stall4), 32'd0);
    checkOutput("arst async fw_sel", 32'(fwSel4), 32'h0);
    @(negedge clk);
    #2 arst = 1'b0;
    applyStimulus(1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
    stepCycle();
    #2 checkOutput("arst post no stall", 32'(stall4), 32'd0);
    stepCycle();
    checkOutput("arst post count", 32'(count4), 32'd0);

    // Randomised traffic over a small register range to force frequent matches.
    for (int n = 0; n < 4000; n++) begin
      arst = ($urandom_range(0, 199) == 0);
      applyStimulus($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
      stepCycle();
    end
    arst = 1'b0;
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    stepCycle();
    stepCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
